dct_transpose_buf: RTL and testbench

- Double-buffered 8x8 transpose memory between the row-pass dct_1D and the column-pass dct_1D of the 2-D DCT.
- Accepts one 8-coefficient row per beat from the row DCT.
- After a full block, presents the block column-by-column on a valid/ready interface.
- Ping-pong banks let one block be written while the previous block is read.

---
 rtl/dct_transpose_buf.sv | 132 +++++++++++++
 tb/tb_dct_transpose_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buf.sv
// Double-buffered 8x8 transpose memory between the row-pass and column-pass 1-D DCTs.
// Rows are written into one bank while the other bank is read out column by column.
module dct_transpose_buf #(
   parameter int unsigned DW = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in0,
   input  logic signed [DW-1:0] in1,
   input  logic signed [DW-1:0] in2,
   input  logic signed [DW-1:0] in3,
   input  logic signed [DW-1:0] in4,
   input  logic signed [DW-1:0] in5,
   input  logic signed [DW-1:0] in6,
   input  logic signed [DW-1:0] in7,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out0,
   output logic signed [DW-1:0] out1,
   output logic signed [DW-1:0] out2,
   output logic signed [DW-1:0] out3,
   output logic signed [DW-1:0] out4,
   output logic signed [DW-1:0] out5,
   output logic signed [DW-1:0] out6,
   output logic signed [DW-1:0] out7,
   output logic [2:0]           out_col,
   output logic                 out_last,
   output logic                 overflow
);

   // Storage: bank, row, column
   logic signed [DW-1:0] mem [2][8][8];

   logic signed [DW-1:0] in_row  [8];
   logic signed [DW-1:0] out_row [8];

   logic       wr_sel;
   logic [2:0] wr_row;
   logic       rd_sel;
   logic [2:0] rd_col;
   logic [1:0] full;
   logic [1:0] full_nxt;

   logic wr_en;
   logic rd_en;
   logic wr_done;
   logic rd_done;

   assign in_row[0] = in0;
   assign in_row[1] = in1;
   assign in_row[2] = in2;
   assign in_row[3] = in3;
   assign in_row[4] = in4;
   assign in_row[5] = in5;
   assign in_row[6] = in6;
   assign in_row[7] = in7;

   assign in_ready  = ~full[wr_sel];
   assign out_valid = full[rd_sel];

   assign wr_en   = in_valid & in_ready;
   assign rd_en   = out_valid & out_ready;
   assign wr_done = wr_en & (wr_row == 3'd7);
   assign rd_done = rd_en & (rd_col == 3'd7);

   // Full flags: a finishing write and a finishing read always target different banks
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wr_sel] = 1'b1;
      if (rd_done) full_nxt[rd_sel] = 1'b0;
   end

   // Bank write: one row per accepted beat; contents are not reset
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int c = 0; c < 8; c++) begin
            mem[wr_sel][wr_row][c] <= in_row[c];
         end
      end
   end

   // Control state: write/read pointers, bank select, full flags, sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_sel   <= 1'b0;
         wr_row   <= 3'd0;
         rd_sel   <= 1'b0;
         rd_col   <= 3'd0;
         full     <= 2'b00;
         overflow <= 1'b0;
      end else begin
         full <= full_nxt;
         if (wr_en) begin
            wr_row <= wr_row + 3'd1;
            if (wr_done) wr_sel <= ~wr_sel;
         end
         if (in_valid && !in_ready) overflow <= 1'b1;
         if (rd_en) begin
            rd_col <= rd_col + 3'd1;
            if (rd_done) rd_sel <= ~rd_sel;
         end
      end
   end

   // Column read mux; everything is zeroed while no column is presented
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         out_row[k] = '0;
      end
      out_col  = 3'd0;
      out_last = 1'b0;
      if (out_valid) begin
         for (int k = 0; k < 8; k++) begin
            out_row[k] = mem[rd_sel][k][rd_col];
         end
         out_col  = rd_col;
         out_last = (rd_col == 3'd7);
      end
   end

   assign out0 = out_row[0];
   assign out1 = out_row[1];
   assign out2 = out_row[2];
   assign out3 = out_row[3];
   assign out4 = out_row[4];
   assign out5 = out_row[5];
   assign out6 = out_row[6];
   assign out7 = out_row[7];

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed self-checking bench for the 8x8 ping-pong transpose buffer.
module tb_dct_transpose_buf;

   localparam int DW = 20;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] din [8];
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dout [8];
   logic [2:0]    out_col;
   logic          out_last;
   logic          overflow;

   int n_cmp;
   int n_err;

   dct_transpose_buf #(.DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in0      (din[0]),
      .in1      (din[1]),
      .in2      (din[2]),
      .in3      (din[3]),
      .in4      (din[4]),
      .in5      (din[5]),
      .in6      (din[6]),
      .in7      (din[7]),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out0     (dout[0]),
      .out1     (dout[1]),
      .out2     (dout[2]),
      .out3     (dout[3]),
      .out4     (dout[4]),
      .out5     (dout[5]),
      .out6     (dout[6]),
      .out7     (dout[7]),
      .out_col  (out_col),
      .out_last (out_last),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected coefficient: mode 0 = 100*b + r*8 + c, mode 1 = alternating full-scale extremes
   function automatic logic [DW-1:0] gen(input int mode, input int b, input int r, input int c);
      if (mode == 1) return (c % 2 == 0) ? DW'(-524288) : DW'(524287);
      return DW'(100 * b + r * 8 + c);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int mode, input int b, input int r);
      for (int c = 0; c < 8; c++) din[c] = gen(mode, b, r, c);
   endtask

   task automatic check_col(input int mode, input int b, input int c);
      chk("col_valid", 32'(out_valid), 32'd1);
      chk("col_index", 32'(out_col), 32'(c));
      chk("col_last", 32'(out_last), 32'(c == 7));
      for (int k = 0; k < 8; k++) chk("col_data", 32'(dout[k]), 32'(gen(mode, b, k, c)));
   endtask

   // Write 8 rows back to back; optionally confirm the block is not visible early
   task automatic write_block(input int mode, input int b, input bit check_empty);
      for (int r = 0; r < 8; r++) begin
         in_valid = 1'b1;
         set_row(mode, b, r);
         chk("wr_ready", 32'(in_ready), 32'd1);
         tick();
         if (check_empty && r < 7) chk("early_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
   endtask

   task automatic read_block(input int mode, input int b);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check_col(mode, b, c);
         tick();
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      set_row(0, 9, 0);

      // Reset held two cycles with a row offered: nothing may be stored
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_overflow", 32'(overflow), 32'd0);
         chk("rst_out_col", 32'(out_col), 32'd0);
         chk("rst_out_last", 32'(out_last), 32'd0);
         for (int k = 0; k < 8; k++) chk("rst_out_data", 32'(dout[k]), 32'd0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();

      // Single block transpose; valid must rise exactly the cycle after row 7
      out_ready = 1'b1;
      write_block(0, 0, 1'b1);
      read_block(0, 0);
      chk("single_after_valid", 32'(out_valid), 32'd0);
      chk("single_after_last", 32'(out_last), 32'd0);

      // Full-range signed data
      write_block(1, 0, 1'b1);
      read_block(1, 0);
      chk("range_after_valid", 32'(out_valid), 32'd0);

      // Back-pressure: 17 rows with out_ready low, last one must be dropped
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         set_row(0, 1 + i / 8, i % 8);
         chk("bp_in_ready", 32'(in_ready), 32'(i < 16));
         chk("bp_overflow_pre", 32'(overflow), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      chk("bp_overflow", 32'(overflow), 32'd1);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      // Data must hold while stalled
      check_col(0, 1, 0);
      tick();
      check_col(0, 1, 0);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check_col(0, 1, c);
         chk("bp_drain_ready", 32'(in_ready), 32'd0);
         tick();
      end
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      read_block(0, 2);
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("bp_overflow_sticky", 32'(overflow), 32'd1);

      // Streaming: four blocks, continuous writes overlapped with reads
      out_ready = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (t < 32) begin
            in_valid = 1'b1;
            set_row(0, t / 8, t % 8);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         if (t < 8) chk("stream_pre_valid", 32'(out_valid), 32'd0);
         else check_col(0, (t - 8) / 8, (t - 8) % 8);
         tick();
      end
      chk("stream_done", 32'(out_valid), 32'd0);

      // Reset mid-operation: block 0 at column 3, block 1 at row 4
      rst = 1'b0;
      for (int t = 0; t < 13; t++) begin
         in_valid  = 1'b1;
         set_row(0, 5 + t / 8, t % 8);
         out_ready = (t >= 10);
         tick();
      end
      chk("mid_pre_col", 32'(out_col), 32'd3);
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      chk("mid_out_col", 32'(out_col), 32'd0);
      chk("mid_overflow", 32'(overflow), 32'd0);
      write_block(0, 6, 1'b1);
      read_block(0, 6);
      chk("mid_final_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
